// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: register offsets,
// CTRL field layout and the active-low hex segment encoding.
package seg7_pkg;

    localparam logic [31:0] VALUE_OFS = 32'd0;
    localparam logic [31:0] CTRL_OFS  = 32'd4;

    localparam int DP_LSB  = 0;
    localparam int EN_BIT  = 4;
    localparam int LZB_BIT = 5;

    typedef struct packed {
        logic       lzb;
        logic       en;
        logic [3:0] dp;
    } ctrl_t;

    // Segments {g,f,e,d,c,b,a}, active low; entry 15 first, entry 0 last.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// CPU peripheral bus as seen by the seven-segment controller.
interface seg7_scan_ctrl_if;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (output MemWrite, output Address, output WriteData, input ReadData);
    modport slave  (input MemWrite, input Address, input WriteData, output ReadData);
endinterface

// File: rtl/seg7_decode.sv
// Combinational hex digit to active-low seven-segment pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    assign seg = SEG_LUT[hex];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Memory-mapped 4-digit common-anode display controller with hardware scan
// and frame-aligned (tear-free) value updates.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int          REFRESH_DIV = 100000,
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0010
) (
    input  logic              sysclk,
    input  logic              reset,
    seg7_scan_ctrl_if.slave   bus,
    output logic [7:0]        Cathodes,
    output logic [3:0]        AN
);
    localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [1:0]       idx, idx_nxt;
    logic [15:0]      pending, shown, shown_nxt;
    ctrl_t            ctrl, ctrl_nxt;
    logic             wr_value, wr_ctrl, tick, load, blank;
    logic [3:0]       nib;
    logic [6:0]       seg, seg_out;
    logic [3:0]       an_nxt;
    logic [7:0]       cat_nxt;

    assign wr_value = bus.MemWrite && (bus.Address == BASE_ADDR + VALUE_OFS);
    assign wr_ctrl  = bus.MemWrite && (bus.Address == BASE_ADDR + CTRL_OFS);
    assign tick     = (div == DIV_LAST);
    assign idx_nxt  = tick ? idx + 2'd1 : idx;

    always_comb begin
        bus.ReadData = 32'd0;
        if (bus.Address == BASE_ADDR + VALUE_OFS)
            bus.ReadData = {16'd0, pending};
        else if (bus.Address == BASE_ADDR + CTRL_OFS)
            bus.ReadData = {26'd0, ctrl};
    end

    // While disabled the shadow tracks pending continuously, so enabling never shows stale data.
    assign load      = (tick && idx == 2'd3) || !ctrl.en;
    assign shown_nxt = load ? (wr_value ? bus.WriteData[15:0] : pending) : shown;
    assign ctrl_nxt  = wr_ctrl ? ctrl_t'(bus.WriteData[5:0]) : ctrl;

    assign nib = shown_nxt[{idx_nxt, 2'b00} +: 4];

    seg7_decode u_decode (
        .hex (nib),
        .seg (seg)
    );

    always_comb begin
        unique case (idx_nxt)
            2'd3:    blank = (shown_nxt[15:12] == 4'd0);
            2'd2:    blank = (shown_nxt[15:8]  == 8'd0);
            2'd1:    blank = (shown_nxt[15:4]  == 12'd0);
            default: blank = 1'b0;
        endcase
        seg_out = (ctrl_nxt.lzb && blank) ? 7'h7F : seg;
        an_nxt  = ctrl_nxt.en ? ~(4'b0001 << idx_nxt) : 4'hF;
        cat_nxt = ctrl_nxt.en ? {~ctrl_nxt.dp[idx_nxt], seg_out} : 8'hFF;
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            div      <= '0;
            idx      <= 2'd0;
            pending  <= 16'd0;
            ctrl     <= '0;
            shown    <= 16'd0;
            AN       <= 4'hF;
            Cathodes <= 8'hFF;
        end else begin
            div   <= tick ? '0 : div + DIV_W'(1);
            idx   <= idx_nxt;
            ctrl  <= ctrl_nxt;
            shown <= shown_nxt;
            if (wr_value)
                pending <= bus.WriteData[15:0];
            if (tick || wr_ctrl) begin
                AN       <= an_nxt;
                Cathodes <= cat_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized self-checking bench for seg7_scan_ctrl against a time-based display model.
module tb_seg7_scan_ctrl;
    localparam int          RD   = 4;
    localparam logic [31:0] BASE = 32'h4000_0010;

    logic       sysclk;
    logic       reset;
    logic [7:0] Cathodes;
    logic [3:0] AN;

    seg7_scan_ctrl_if bus ();

    seg7_scan_ctrl #(.REFRESH_DIV(RD), .BASE_ADDR(BASE)) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .bus      (bus),
        .Cathodes (Cathodes),
        .AN       (AN)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    // Full cathode bytes for each hex digit with the DP off.
    logic [7:0] dec [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    int          checks   = 0;
    int          failures = 0;
    int unsigned tcnt;
    logic [15:0] m_pend, m_shown;
    logic [5:0]  m_ctrl;
    logic [3:0]  m_an;
    logic [7:0]  m_cat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0d)", name, act, exp, tcnt);
        end
    endtask

    task automatic model_reset();
        tcnt = 0; m_pend = 16'd0; m_shown = 16'd0; m_ctrl = 6'd0;
        m_an = 4'hF; m_cat = 8'hFF;
    endtask

    function automatic logic [31:0] m_rd(input logic [31:0] a);
        if (a == BASE)          return {16'd0, m_pend};
        else if (a == BASE + 4) return {26'd0, m_ctrl};
        else                    return 32'd0;
    endfunction

    // Slot position is purely a function of cycles since reset.
    task automatic model_step(input logic we, input logic [31:0] a, input logic [31:0] d);
        logic       tk, en;
        int         i_old, i_new;
        logic [6:0] seg;
        tk    = (tcnt % RD) == RD - 1;
        i_old = (tcnt / RD) % 4;
        i_new = tk ? (i_old + 1) % 4 : i_old;
        if (!m_ctrl[4] || (tk && i_old == 3))
            m_shown = (we && a == BASE) ? d[15:0] : m_pend;
        if (we && a == BASE) m_pend = d[15:0];
        if (we && a == BASE + 4) begin
            m_ctrl = d[5:0];
        end
        if (tk || (we && a == BASE + 4)) begin
            en  = m_ctrl[4];
            seg = dec[(m_shown >> (4 * i_new)) & 16'hF][6:0];
            if (m_ctrl[5] && i_new != 0 && (m_shown >> (4 * i_new)) == 0) seg = 7'h7F;
            m_an  = en ? ~(4'b0001 << i_new) : 4'hF;
            m_cat = en ? {~m_ctrl[i_new], seg} : 8'hFF;
        end
        tcnt++;
    endtask

    task automatic tick1(input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.MemWrite = we; bus.Address = a; bus.WriteData = d;
        #1;
        chk("readdata", bus.ReadData, m_rd(a));
        @(posedge sysclk);
        model_step(we, a, d);
        #1;
        chk("an", {28'd0, AN}, {28'd0, m_an});
        chk("cathodes", {24'd0, Cathodes}, {24'd0, m_cat});
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return BASE;
            1:       return BASE + 4;
            2:       return BASE + 8;
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_to(input int unsigned t);
        while (tcnt < t) tick1(1'b0, pick_addr(), $urandom);
    endtask

    task automatic lit(input string name, input logic [3:0] an_e, input logic [7:0] cat_e);
        chk({name, "_an"}, {28'd0, AN}, {28'd0, an_e});
        chk({name, "_cat"}, {24'd0, Cathodes}, {24'd0, cat_e});
    endtask

    initial begin
        reset = 1'b1;
        bus.MemWrite = 1'b0; bus.Address = BASE; bus.WriteData = 32'd0;
        model_reset();
        #22;
        lit("rst_held", 4'hF, 8'hFF);
        chk("rst_value_rd", bus.ReadData, 32'd0);
        @(posedge sysclk); #1;
        reset = 1'b0;

        tick1(1'b1, BASE, 32'hABCD_12AB);
        lit("before_ctrl", 4'hF, 8'hFF);
        tick1(1'b1, BASE + 4, 32'h10);
        lit("en_d0", 4'hE, 8'h83);
        wait_to(4);  lit("f0_d1", 4'hD, 8'h88);
        wait_to(8);  lit("f0_d2", 4'hB, 8'hA4);
        wait_to(12); lit("f0_d3", 4'h7, 8'hF9);
        wait_to(16); lit("f1_d0", 4'hE, 8'h83);
        tick1(1'b1, BASE, 32'h0007);
        wait_to(20); lit("tearfree_d1", 4'hD, 8'h88);
        wait_to(32); lit("newframe_d0", 4'hE, 8'hF8);
        wait_to(33);
        tick1(1'b1, BASE + 4, 32'h30);
        lit("lzb_d0", 4'hE, 8'hF8);
        wait_to(36); lit("lzb_d1", 4'hD, 8'hFF);
        wait_to(40); lit("lzb_d2", 4'hB, 8'hFF);
        tick1(1'b1, BASE + 4, 32'h15);
        lit("dp_d2", 4'hB, 8'h40);
        wait_to(44); lit("dp_d3", 4'h7, 8'hC0);
        wait_to(48); lit("dp_d0", 4'hE, 8'h78);
        wait_to(52); lit("dp_d1", 4'hD, 8'hC0);
        tick1(1'b1, BASE + 4, 32'h35);
        lit("blank_dp_off", 4'hD, 8'hFF);
        wait_to(56); lit("blank_dp_on", 4'hB, 8'h7F);

        wait_to(63);
        tick1(1'b1, BASE, 32'h0000_5C3E);
        lit("boundary_wr", 4'hE, 8'h06);
        bus.MemWrite = 1'b0; bus.Address = BASE + 8; #1;
        chk("unmapped_rd", bus.ReadData, 32'd0);

        repeat (400) tick1($urandom_range(0, 7) == 0, pick_addr(), $urandom);

        tick1(1'b1, BASE + 4, 32'h10);
        wait_to(tcnt + 2);
        #2 reset = 1'b1;
        #1;
        model_reset();
        lit("async_rst", 4'hF, 8'hFF);
        @(posedge sysclk); #1;
        reset = 1'b0;
        bus.Address = BASE; #1;
        chk("rst_value_after", bus.ReadData, 32'd0);
        wait_to(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
